instr_fetch_queue: RTL and testbench

//  Fetch stage between the program counter and decode. Issues instruction-memory requests for the

---
 rtl/instr_fetch_queue_if.sv | 31 +++
 rtl/instr_fetch_queue.sv | 132 +++++++++++++
 tb/tb_instr_fetch_queue.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_queue_if.sv
// Bundle of the instruction-memory request/response channel and the decode
// handshake. The master modport is the fetch queue; the slave modport is the
// memory/decode side.
`timescale 1ns/1ps
interface instr_fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_instr;
    logic            id_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output id_valid, id_pc, id_instr,
        input  id_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  id_valid, id_pc, id_instr,
        output id_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage between the program counter and decode. Requests are tagged with
// their PC in a tag FIFO, in-order responses are buffered in a small queue and
// presented to decode. A redirect (j_br) clears the queue and marks every
// still-in-flight response dead so it is discarded on return.
// Optional feature macro: IFQ_BYPASS_EN (live response straight to decode when
// the queue is empty).
`timescale 1ns/1ps
module instr_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        fetch_pc,
    input  logic                   j_br,
    output logic                   pc_stall,
    output logic [$clog2(DEPTH):0] ifq_count,
    instr_fetch_queue_if.master    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0] q_pc_mem    [DEPTH];
    logic [XLEN-1:0] q_instr_mem [DEPTH];
    logic [XLEN-1:0] tag_mem     [DEPTH];

    logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
    logic [CNT_W-1:0] out_q, out_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [PTR_W-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;

    logic [CNT_W:0]   credit;
    logic             req, accept, rsp, live, push, pop, q_nonempty;
    logic [XLEN-1:0]  head_pc, head_instr, tag_head;
`ifdef IFQ_BYPASS_EN
    logic             byp_show, byp_take;
`endif

    // Request credit, response liveness and the decode-facing view of the head.
    always_comb begin
        credit     = {1'b0, out_q} + {1'b0, q_cnt_q};
        req        = !j_br && (credit < {1'b0, DEPTH_CNT});
        accept     = req && bus.imem_gnt;
        rsp        = bus.imem_rvalid && (out_q != '0);
        live       = rsp && (drop_q == '0) && !j_br;
        q_nonempty = (q_cnt_q != '0);
        pop        = q_nonempty && bus.id_ready && !j_br;
        head_pc    = q_pc_mem[q_rd_q];
        head_instr = q_instr_mem[q_rd_q];
        tag_head   = tag_mem[tag_rd_q];
`ifdef IFQ_BYPASS_EN
        byp_show     = live && !q_nonempty;
        byp_take     = byp_show && bus.id_ready;
        push         = live && !byp_take;
        bus.id_valid = q_nonempty || byp_show;
        bus.id_pc    = byp_show ? tag_head : head_pc;
        bus.id_instr = byp_show ? bus.imem_rdata : head_instr;
`else
        push         = live;
        bus.id_valid = q_nonempty;
        bus.id_pc    = head_pc;
        bus.id_instr = head_instr;
`endif
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign pc_stall      = !accept;
    assign ifq_count     = q_cnt_q;

    // Next-state for queue pointers, in-flight count and dead-response count.
    always_comb begin
        q_cnt_d  = q_cnt_q;
        q_rd_d   = q_rd_q;
        q_wr_d   = q_wr_q;
        drop_d   = drop_q;
        out_d    = out_q + CNT_W'(accept) - CNT_W'(rsp);
        tag_wr_d = accept ? tag_wr_q + PTR_W'(1) : tag_wr_q;
        tag_rd_d = rsp    ? tag_rd_q + PTR_W'(1) : tag_rd_q;
        if (j_br) begin
            // Everything still in flight after this cycle is dead; recomputing
            // from the in-flight count keeps back-to-back redirects exact.
            q_cnt_d = '0;
            q_rd_d  = '0;
            q_wr_d  = '0;
            drop_d  = out_q - CNT_W'(rsp);
        end else begin
            q_rd_d  = pop  ? q_rd_q + PTR_W'(1) : q_rd_q;
            q_wr_d  = push ? q_wr_q + PTR_W'(1) : q_wr_q;
            q_cnt_d = q_cnt_q + CNT_W'(push) - CNT_W'(pop);
            drop_d  = drop_q - CNT_W'(rsp && (drop_q != '0));
        end
    end

    // Control state; asynchronous reset empties queue, tag FIFO and counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_cnt_q  <= '0;
            q_rd_q   <= '0;
            q_wr_q   <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            q_cnt_q  <= q_cnt_d;
            q_rd_q   <= q_rd_d;
            q_wr_q   <= q_wr_d;
            out_q    <= out_d;
            drop_q   <= drop_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    // Payload storage; contents are only meaningful under the pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wr_q] <= fetch_pc;
        end
        if (push) begin
            q_pc_mem[q_wr_q]    <= tag_head;
            q_instr_mem[q_wr_q] <= bus.imem_rdata;
        end
    end

    // A response with nothing in flight is a memory-side protocol violation.
    assert property (@(posedge clk) disable iff (reset) !(bus.imem_rvalid && (out_q == '0)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
`timescale 1ns/1ps
module tb_instr_fetch_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetch_pc;
    logic        j_br;
    logic        pc_stall;
    logic [2:0]  ifq_count;

    instr_fetch_queue_if #(.XLEN(XLEN)) bus ();

    instr_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .fetch_pc  (fetch_pc),
        .j_br      (j_br),
        .pc_stall  (pc_stall),
        .ifq_count (ifq_count),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; bit dead; } fl_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } qe_t;

    // Reference model: in-flight requests and decode queue as plain queues
    fl_t         infl[$];
    qe_t         mq[$];
    // Environment: memory pending addresses, program counter, observed handoffs
    logic [31:0] mem[$];
    logic [31:0] obs[$];
    logic [31:0] pc, bta;
    int          gnt_pct, rv_pct, rdy_pct, jbr_pct;
    bit          force_jbr;
    int          acc_cnt;
    int          cyc = 0;
    bit          s_req, s_stall, s_valid;
    logic [2:0]  s_cnt;

    int n_pass = 0;
    int n_tot  = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        j_br            = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        bus.id_ready    = 1'b0;
        fetch_pc        = '0;
        force_jbr       = 1'b0;
        mem.delete(); infl.delete(); mq.delete(); obs.delete();
        pc = '0; bta = '0; acc_cnt = 0;
        @(posedge clk); #1;
        chk("rst_imem_req", bus.imem_req, 1'b1);
        chk("rst_pc_stall", pc_stall, 1'b1);
        chk("rst_id_valid", bus.id_valid, 1'b0);
        chk("rst_ifq_count", ifq_count, 3'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step();
        bit          exp_req, live_now, exp_valid, rsp, live, take, pop, dut_acc, dut_stall;
        logic [31:0] e_pc, e_ins;
        fl_t         f;
        @(negedge clk);
        if (!force_jbr) bta = $urandom & 32'h0000_FFFC;
        j_br            = force_jbr || ($urandom_range(99) < jbr_pct);
        bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        bus.imem_rvalid = (mem.size() > 0) && ($urandom_range(99) < rv_pct);
        bus.imem_rdata  = bus.imem_rvalid ? instr_of(mem[0]) : $urandom;
        bus.id_ready    = ($urandom_range(99) < rdy_pct);
        fetch_pc        = pc;
        #1;
        exp_req   = !j_br && ((infl.size() + mq.size()) < DEPTH);
        live_now  = bus.imem_rvalid && (infl.size() > 0) && !j_br;
        if (live_now) live_now = !infl[0].dead;
        exp_valid = (mq.size() > 0) || (BYP && live_now);
        chk("imem_req", bus.imem_req, exp_req);
        chk("pc_stall", pc_stall, !(exp_req && bus.imem_gnt));
        chk("imem_addr", bus.imem_addr, fetch_pc);
        chk("ifq_count", ifq_count, 64'(mq.size()));
        chk("id_valid", bus.id_valid, exp_valid);
        if (exp_valid) begin
            if (mq.size() > 0) begin
                e_pc = mq[0].pc; e_ins = mq[0].instr;
            end else begin
                e_pc = infl[0].pc; e_ins = bus.imem_rdata;
            end
            chk("id_pc", bus.id_pc, e_pc);
            chk("id_instr", bus.id_instr, e_ins);
        end
        s_req = bus.imem_req; s_stall = pc_stall; s_valid = bus.id_valid; s_cnt = ifq_count;
        if (bus.id_valid && bus.id_ready && !j_br) obs.push_back(bus.id_pc);
        dut_acc   = bus.imem_req && bus.imem_gnt;
        dut_stall = pc_stall;
        @(posedge clk);
        // environment
        if (bus.imem_rvalid) mem.delete(0);
        if (dut_acc) begin mem.push_back(pc); acc_cnt++; end
        if (j_br) pc = bta;
        else if (!dut_stall) pc = pc + 32'd4;
        // model
        rsp  = bus.imem_rvalid && (infl.size() > 0);
        live = 1'b0;
        if (rsp) begin
            f = infl.pop_front();
            live = !f.dead && !j_br;
        end
        if (j_br) begin
            mq.delete();
            foreach (infl[i]) infl[i].dead = 1'b1;
        end else begin
            take = BYP && live && (mq.size() == 0) && bus.id_ready;
            pop  = (mq.size() > 0) && bus.id_ready;
            if (pop) mq.delete(0);
            if (live && !take) mq.push_back('{f.pc, bus.imem_rdata});
        end
        if (exp_req && bus.imem_gnt) infl.push_back('{fetch_pc, 1'b0});
        cyc++;
    endtask

    task automatic set_mode(input int g, input int r, input int d, input int j);
        gnt_pct = g; rv_pct = r; rdy_pct = d; jbr_pct = j;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        set_mode(0, 0, 0, 0);
        // Streaming PCs 0,4,8 with immediate responses and ready decode
        do_reset();
        set_mode(100, 100, 100, 0);
        repeat (6) begin
            step();
            chk("p1_stall", s_stall, 1'b0);
        end
        chk("p1_obs0", obs.size() > 0 ? obs[0] : 32'hx, 32'h0);
        chk("p1_obs1", obs.size() > 1 ? obs[1] : 32'hx, 32'h4);
        chk("p1_obs2", obs.size() > 2 ? obs[2] : 32'hx, 32'h8);

        // Decode stalled: credit limits requests to DEPTH
        do_reset();
        set_mode(100, 100, 0, 0);
        repeat (10) step();
        chk("p2_acc", acc_cnt, 4);
        chk("p2_cnt", s_cnt, 3'd4);
        chk("p2_req", s_req, 1'b0);
        chk("p2_stall", s_stall, 1'b1);
        set_mode(100, 100, 100, 0);
        step();
        set_mode(100, 100, 0, 0);
        step();
        chk("p2_req_after_pop", s_req, 1'b1);
        repeat (3) step();
        chk("p2_acc_after_pop", acc_cnt, 5);
        chk("p2_cnt_after_pop", s_cnt, 3'd4);

        // Redirect with 3 requests in flight
        do_reset();
        set_mode(100, 0, 100, 0);
        repeat (3) step();
        chk("p3_acc", acc_cnt, 3);
        force_jbr = 1'b1; bta = 32'h100;
        step();
        force_jbr = 1'b0;
        obs.delete();
        set_mode(100, 100, 100, 0);
        step();
        chk("p3_cnt_cleared", s_cnt, 3'd0);
        chk("p3_dead_invalid", s_valid, 1'b0);
        repeat (12) step();
        chk("p3_first_pc", obs.size() > 0 ? obs[0] : 32'hx, 32'h100);
        chk("p3_second_pc", obs.size() > 1 ? obs[1] : 32'hx, 32'h104);

        // Redirect coinciding with a response and ready decode, 2 outstanding
        do_reset();
        set_mode(100, 0, 0, 0);
        repeat (2) step();
        force_jbr = 1'b1; bta = 32'h200;
        set_mode(100, 100, 100, 0);
        step();
        chk("p4_jbr_valid", s_valid, 1'b0);
        force_jbr = 1'b0;
        obs.delete();
        step();
        chk("p4_dead_valid", s_valid, 1'b0);
        chk("p4_cnt", s_cnt, 3'd0);
        repeat (10) step();
        chk("p4_first_pc", obs.size() > 0 ? obs[0] : 32'hx, 32'h200);

        // Grant withheld: PC holds and the same PC is requested on grant
        do_reset();
        pc = 32'h40;
        set_mode(0, 100, 100, 0);
        repeat (5) begin
            step();
            chk("p5_req", s_req, 1'b1);
            chk("p5_stall", s_stall, 1'b1);
        end
        chk("p5_pc_hold", pc, 32'h40);
        set_mode(100, 0, 100, 0);
        step();
        chk("p5_stall_gnt", s_stall, 1'b0);
        chk("p5_addr", mem.size() > 0 ? mem[0] : 32'hx, 32'h40);
        chk("p5_pc_adv", pc, 32'h44);

        // Response into an empty queue with decode ready
        do_reset();
        set_mode(100, 0, 100, 0);
        step();
        set_mode(0, 0, 100, 0);
        step();
        obs.delete();
        set_mode(0, 100, 100, 0);
        step();
`ifdef IFQ_BYPASS_EN
        chk("p6_byp_valid", s_valid, 1'b1);
        chk("p6_byp_cnt", s_cnt, 3'd0);
        chk("p6_byp_pc", obs.size() > 0 ? obs[0] : 32'hx, 32'h0);
        step();
        chk("p6_byp_cnt_next", s_cnt, 3'd0);
        chk("p6_byp_valid_next", s_valid, 1'b0);
`else
        chk("p6_q_valid", s_valid, 1'b0);
        step();
        chk("p6_q_valid_next", s_valid, 1'b1);
        chk("p6_q_cnt_next", s_cnt, 3'd1);
`endif

        // Randomized traffic with redirects and mid-operation resets
        for (int r = 0; r < 4; r++) begin
            do_reset();
            pc = $urandom & 32'h0000_FFFC;
            set_mode($urandom_range(20, 100), $urandom_range(20, 100),
                     $urandom_range(10, 100), 5);
            repeat (700) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
